mac_seq_ctrl: RTL and testbench

Sequencer that computes one dot product per request by streaming activation/weight pairs from two synchronous-read SRAMs through a combinational MAC. The MAC is a*b+c with a unsigned, b signed and c the partial sum. Sits between the layer-level controller (start, len, base_addr, result handshake) and the activation/weight memories. It owns the address counter, the read-latency alignment, the psum register and the result valid/ready handshake.

---
 rtl/mac_pkg.sv | 8 +
 rtl/mac_seq_ctrl_if.sv | 31 +++
 rtl/mac_seq_ctrl_mac.sv | 18 +
 rtl/mac_seq_ctrl.sv | 67 ++++++
 tb/tb_mac_seq_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the MAC datapath
package mac_pkg;
  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int ADDR_BW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - request, SRAM read port and result handshake of the dot-product sequencer
interface mac_seq_ctrl_if
  import mac_pkg::*;
#(
  parameter int BW      = mac_pkg::BW,
  parameter int PSUM_BW = mac_pkg::PSUM_BW,
  parameter int ADDR_BW = mac_pkg::ADDR_BW
);
  logic               start;
  logic [ADDR_BW-1:0] len;
  logic [ADDR_BW-1:0] base_addr;
  logic               acc_mode;
  logic               rd_en;
  logic [ADDR_BW-1:0] rd_addr;
  logic [BW-1:0]      x_q;
  logic [BW-1:0]      w_q;
  logic               busy;
  logic [PSUM_BW-1:0] result;
  logic               result_valid;
  logic               result_ready;

  modport master (
    output start, len, base_addr, acc_mode, x_q, w_q, result_ready,
    input  rd_en, rd_addr, busy, result, result_valid
  );

  modport slave (
    input  start, len, base_addr, acc_mode, x_q, w_q, result_ready,
    output rd_en, rd_addr, busy, result, result_valid
  );
endinterface

// File: rtl/mac_seq_ctrl_mac.sv
// rtl/mac_seq_ctrl_mac.sv - combinational multiply-accumulate, unsigned activation times signed weight
module mac #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16
) (
  input  logic        [BW-1:0]      a,
  input  logic signed [BW-1:0]      b,
  input  logic signed [PSUM_BW-1:0] c,
  output logic signed [PSUM_BW-1:0] out
);
  logic signed [PSUM_BW-1:0] a_ext;
  logic signed [PSUM_BW-1:0] b_ext;

  // Both operands widened to psum width so the product and sum wrap at psum_bw.
  assign a_ext = {{(PSUM_BW-BW){1'b0}}, a};
  assign b_ext = {{(PSUM_BW-BW){b[BW-1]}}, b};
  assign out   = a_ext * b_ext + c;
endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - streams activation/weight pairs from SRAM through the MAC, one dot product per request
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int BW      = mac_pkg::BW,
  parameter int PSUM_BW = mac_pkg::PSUM_BW,
  parameter int ADDR_BW = mac_pkg::ADDR_BW
) (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.slave  bus
);
  state_t                    state_q, state_d;
  logic [ADDR_BW-1:0]        idx_q, len_q, base_q;
  logic                      d_vld_q;
  logic signed [PSUM_BW-1:0] psum_q, mac_out;
  logic                      run;

  assign run              = (state_q == RUN);
  assign bus.rd_en        = run;
  assign bus.rd_addr      = run ? (base_q + idx_q) : '0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = psum_q;

  mac #(.BW(BW), .PSUM_BW(PSUM_BW)) u_mac (
    .a   (bus.x_q),
    .b   (bus.w_q),
    .c   (psum_q),
    .out (mac_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len != '0) ? RUN : DONE;
      RUN:     if (idx_q == len_q - 1'b1) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      d_vld_q <= 1'b0;
      psum_q  <= '0;
    end else begin
      state_q <= state_d;
      // SRAM data lags the read strobe by one cycle; d_vld_q marks when it is valid.
      d_vld_q <= run;
      if (state_q == IDLE && bus.start) begin
        len_q  <= bus.len;
        base_q <= bus.base_addr;
        idx_q  <= '0;
        if (!bus.acc_mode) psum_q <= '0;
      end else begin
        if (run) idx_q <= idx_q + 1'b1;
        if (d_vld_q) psum_q <= mac_out;
      end
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed checks of the dot-product sequencer with a synchronous-read SRAM model
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [3:0] x_mem [16];
  logic [3:0] w_mem [16];

  mac_seq_ctrl_if bus ();

  mac_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.x_q <= x_mem[bus.rd_addr];
      bus.w_q <= w_mem[bus.rd_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
  endtask

  // Issues one request at cycle 0 and checks every cycle through the result handshake.
  task automatic run(input string tag, input int len, input int base, input bit acc,
                     input logic [15:0] exp, input int hold, input bit poke_start);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.len       = 4'(len);
    bus.base_addr = 4'(base);
    bus.acc_mode  = acc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= len; k++) begin
      check({tag, "_run_rd_en"}, 32'(bus.rd_en), 32'd1);
      check({tag, "_run_rd_addr"}, 32'(bus.rd_addr), 32'((base + k - 1) % 16));
      check({tag, "_run_valid"}, 32'(bus.result_valid), 32'd0);
      @(negedge clk);
    end
    if (len != 0) begin
      check({tag, "_drain_rd_en"}, 32'(bus.rd_en), 32'd0);
      check({tag, "_drain_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_drain_valid"}, 32'(bus.result_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_done_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, "_done_rd_en"}, 32'(bus.rd_en), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 1) begin
        bus.start     = 1'b1;
        bus.len       = 4'd2;
        bus.base_addr = 4'd0;
        bus.acc_mode  = 1'b0;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_hold_valid"}, 32'(bus.result_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), 32'(exp));
      check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check({tag, "_ack_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_ack_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      x_mem[i] = 4'd0;
      w_mem[i] = 4'd0;
    end
    x_mem[0] = 4'd1;  w_mem[0] = 4'd1;
    x_mem[1] = 4'd2;  w_mem[1] = 4'hF;
    x_mem[2] = 4'd3;  w_mem[2] = 4'd2;
    x_mem[3] = 4'd15; w_mem[3] = 4'h8;
    x_mem[4] = 4'd4;  w_mem[4] = 4'd3;
    x_mem[14] = 4'd5; w_mem[14] = 4'd2;
    x_mem[15] = 4'd7; w_mem[15] = 4'hD;

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.len          = '0;
    bus.base_addr    = '0;
    bus.acc_mode     = 1'b0;
    bus.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run("dot3", 3, 0, 1'b0, 16'h0005, 0, 1'b0);
    run("acc1", 1, 4, 1'b1, 16'h0011, 0, 1'b0);
    run("acc0", 1, 4, 1'b0, 16'h000C, 0, 1'b0);
    run("sext", 1, 3, 1'b0, 16'hFF88, 0, 1'b0);
    run("len0_acc1", 0, 0, 1'b1, 16'hFF88, 0, 1'b0);
    run("len0_acc0", 0, 0, 1'b0, 16'h0000, 0, 1'b0);
    // -12: 5*2 + 7*(-3) + 1*1 + 2*(-1), addresses wrap past 15.
    run("wrap_hold", 4, 14, 1'b0, 16'hFFF4, 3, 1'b1);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.len       = 4'd5;
    bus.base_addr = 4'd0;
    bus.acc_mode  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("midrun_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    reset = 1'b0;
    run("after_reset", 2, 0, 1'b1, 16'hFFFF, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
